// File: rtl/add_init_pkg.sv
// Shared types and constants for the adder initiator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   TIMER_W - width of the WAIT-state timeout counter (holds 1..255)
//   state_t - initiator FSM encoding
package add_init_pkg;

    localparam int TIMER_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/add_init_timer.sv
// Loadable down-counter that bounds how long the initiator waits for a result.
// Latency: expired_o is combinational from the count and dec_i; the count updates on the next edge.
// Backpressure: none; load_i takes priority over dec_i.
//
// Ports:
//   i_clk, i_rst  clock and asynchronous active-high reset
//   load_i        load the counter with G_TIMEOUT
//   dec_i         decrement the counter (saturates at 0)
//   expired_o     this decrement takes the count to zero
module add_init_timer
    import add_init_pkg::*;
#(
    parameter int G_TIMEOUT = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic load_i,
    input  logic dec_i,
    output logic expired_o
);

    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = TIMER_W'(G_TIMEOUT);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A count of 1 means this is the last allowed empty cycle; a count of 0
    // is treated the same so a stray decrement can never wait forever.
    assign expired_o = dec_i && (cnt_q <= TIMER_W'(1));

endmodule

// File: rtl/add_initiator.sv
// Initiator for the adder: accepts an operand pair, issues one request, returns the sum with ovf/err status.
// Latency: request handshake to o_rsp_valid is 3 cycles with a 1-cycle adder; 4 cycles minimum per transaction.
// Backpressure: o_req_ready is high only in IDLE; the response is held until i_rsp_ready.
//
// Ports:
//   i_clk, i_rst                       clock, asynchronous active-high reset
//   i_req_valid/o_req_ready/i_req_A/B  upstream operand pair (ready/valid)
//   o_add_valid/o_add_A/o_add_B        one-cycle request strobe and latched operands to the adder
//   i_add_valid/i_add_C                adder result
//   o_rsp_valid/i_rsp_ready            downstream response (ready/valid)
//   o_rsp_C/o_rsp_ovf/o_rsp_err        captured sum, carry out, timeout/check error
// Build option: define ADD_INIT_CHECK_EN to compare each result against an internal A+B;
// a mismatch is flagged on o_rsp_err while the adder's value is still returned.
module add_initiator
    import add_init_pkg::*;
#(
    parameter int G_DATA_WIDTH = 3,
    parameter int G_TIMEOUT    = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic [G_DATA_WIDTH-1:0] i_req_A,
    input  logic [G_DATA_WIDTH-1:0] i_req_B,
    output logic                    o_add_valid,
    output logic [G_DATA_WIDTH-1:0] o_add_A,
    output logic [G_DATA_WIDTH-1:0] o_add_B,
    input  logic                    i_add_valid,
    input  logic [G_DATA_WIDTH:0]   i_add_C,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [G_DATA_WIDTH:0]   o_rsp_C,
    output logic                    o_rsp_ovf,
    output logic                    o_rsp_err
);

    localparam int RW = G_DATA_WIDTH + 1;

    state_t                  state_q, state_d;
    logic [G_DATA_WIDTH-1:0] a_q, a_d;
    logic [G_DATA_WIDTH-1:0] b_q, b_d;
    logic [RW-1:0]           c_q, c_d;
    logic                    err_q, err_d;

    logic timer_load;
    logic timer_dec;
    logic timer_expired;
    logic chk_err;

    add_init_timer #(
        .G_TIMEOUT (G_TIMEOUT)
    ) u_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .load_i    (timer_load),
        .dec_i     (timer_dec),
        .expired_o (timer_expired)
    );

`ifdef ADD_INIT_CHECK_EN
    // Reference sum from the operands actually sent to the adder.
    logic [RW-1:0] chk_sum;
    assign chk_sum = RW'(a_q) + RW'(b_q);
    assign chk_err = (chk_sum != i_add_C);
`else
    assign chk_err = 1'b0;
`endif

    // The timer only counts empty WAIT cycles; a returned result stops it.
    assign timer_load = (state_q == ISSUE);
    assign timer_dec  = (state_q == WAIT) && !i_add_valid;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a result in the expiry cycle wins over the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_req_valid) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (i_add_valid || timer_expired) state_d = RESP;
            RESP:    if (i_rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Decoded outputs, driven from the state register only
    always_comb begin
        o_req_ready = 1'b0;
        o_add_valid = 1'b0;
        o_rsp_valid = 1'b0;
        case (state_q)
            IDLE:    o_req_ready = 1'b1;
            ISSUE:   o_add_valid = 1'b1;
            RESP:    o_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values: operands latch on accept, result/status on WAIT exit.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        c_d   = c_q;
        err_d = err_q;
        if ((state_q == IDLE) && i_req_valid) begin
            a_d = i_req_A;
            b_d = i_req_B;
        end
        if (state_q == WAIT) begin
            if (i_add_valid) begin
                c_d   = i_add_C;
                err_d = chk_err;
            end else if (timer_expired) begin
                c_d   = '0;
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            err_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            c_q   <= c_d;
            err_q <= err_d;
        end
    end

    assign o_add_A   = a_q;
    assign o_add_B   = b_q;
    assign o_rsp_C   = c_q;
    assign o_rsp_ovf = c_q[RW-1];
    assign o_rsp_err = err_q;

endmodule
